// File: rtl/push_arbiter_if.sv
// Handshake bundle between the player buttons, light sequencer and scorer.
// master drives buttons/lights; slave is the arbiter producing the round result.
interface push_arbiter_if;
   logic pbl;
   logic pbr;
   logic leds_on;
   logic winrnd;
   logic right;
   logic tie;
   logic leds_lat;
   logic busy;

   modport master (
      output pbl, pbr, leds_on,
      input  winrnd, right, tie, leds_lat, busy
   );

   modport slave (
      input  pbl, pbr, leds_on,
      output winrnd, right, tie, leds_lat, busy
   );
endinterface

// File: rtl/push_arbiter.sv
// Tug-of-war front end: syncs and debounces both buttons, decides who pushed
// first (or a tie), pulses winrnd once, then locks out until both are released.
module push_arbiter #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst,
   push_arbiter_if.slave bus
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] INC  = CW'(1);

   typedef enum logic {
      LOCKOUT = 1'b0,
      ARMED   = 1'b1
   } state_t;

   state_t state;
   state_t state_nx;

   // index 0 = left, index 1 = right
   logic [1:0] raw;
   logic [1:0] s1;
   logic [1:0] s;
   logic [1:0] d;
   logic [1:0] d_q;
   logic [1:0] press;
   logic [CW-1:0] cnt [2];
   logic [CW-1:0] qcnt;

   logic quiet;
   logic arm;
   logic decide;
   logic busy;

   logic winrnd;
   logic right;
   logic tie;
   logic leds_lat;

   assign raw = {bus.pbr, bus.pbl};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s  <= '0;
      end else begin
         s1 <= raw;
         s  <= s1;
      end
   end

   // a level change is taken only after DEBOUNCE_CYCLES disagreeing edges in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         d   <= '0;
         d_q <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         d_q <= d;
         for (int i = 0; i < 2; i++) begin
            if (s[i] != d[i]) begin
               if (cnt[i] == LAST) begin
                  d[i]   <= s[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + INC;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign press = d & ~d_q;
   assign quiet = ~(|s) & ~(|d);

   // quiet counter only runs in LOCKOUT, so it is zero on every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         qcnt <= '0;
      end else if (state == LOCKOUT && quiet && qcnt != LAST) begin
         qcnt <= qcnt + INC;
      end else begin
         qcnt <= '0;
      end
   end

   assign arm = (state == LOCKOUT) && quiet && (qcnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= LOCKOUT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         LOCKOUT: if (arm)    state_nx = ARMED;
         ARMED:   if (|press) state_nx = LOCKOUT;
         default: state_nx = LOCKOUT;
      endcase
   end

   always_comb begin
      decide = 1'b0;
      busy   = 1'b1;
      unique case (state)
         LOCKOUT: busy   = 1'b1;
         ARMED: begin
            busy   = 1'b0;
            decide = |press;
         end
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         winrnd   <= 1'b0;
         right    <= 1'b0;
         tie      <= 1'b0;
         leds_lat <= 1'b0;
      end else begin
         winrnd <= decide;
         if (decide) begin
            tie      <= press[0] & press[1];
            right    <= press[1] & ~press[0];
            leds_lat <= bus.leds_on;
         end
      end
   end

   assign bus.winrnd   = winrnd;
   assign bus.right    = right;
   assign bus.tie      = tie;
   assign bus.leds_lat = leds_lat;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_push_arbiter.sv
// Bench for push_arbiter: window-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_push_arbiter;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;

   push_arbiter_if bus();

   push_arbiter #(.DEBOUNCE_CYCLES(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   bit live    = 0;

   // model state: values held after the most recent edge
   bit m_s1l, m_s1r, m_sl, m_sr;
   bit m_dl, m_dr, m_dlq, m_drq;
   bit m_lock;
   bit m_win, m_right, m_tie, m_leds;
   bit hl[$];
   bit hr[$];
   bit hq[$];

   // true when the last D samples exist and all differ from v
   function automatic bit all_ne(input bit h[$], input bit v);
      if (h.size() < D) return 1'b0;
      foreach (h[i]) if (h[i] == v) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      bit pl, pr, dec, q, ndl, ndr;
      if (rst) begin
         {m_s1l, m_s1r, m_sl, m_sr} = '0;
         {m_dl, m_dr, m_dlq, m_drq} = '0;
         {m_win, m_right, m_tie, m_leds} = '0;
         m_lock = 1'b1;
         hl.delete();
         hr.delete();
         hq.delete();
      end else begin
         pl  = m_dl & ~m_dlq;
         pr  = m_dr & ~m_drq;
         dec = !m_lock && (pl || pr);
         hl.push_back(m_sl);
         hr.push_back(m_sr);
         if (hl.size() > D) void'(hl.pop_front());
         if (hr.size() > D) void'(hr.pop_front());
         ndl = all_ne(hl, m_dl) ? ~m_dl : m_dl;
         ndr = all_ne(hr, m_dr) ? ~m_dr : m_dr;
         q = !(m_sl || m_sr || m_dl || m_dr);
         if (m_lock) begin
            hq.push_back(q);
            if (hq.size() > D) void'(hq.pop_front());
            if (all_ne(hq, 1'b0)) begin
               m_lock = 1'b0;
               hq.delete();
            end
         end else if (dec) begin
            m_lock = 1'b1;
            hq.delete();
         end
         m_win = dec;
         if (dec) begin
            m_tie   = pl & pr;
            m_right = pr & ~pl;
            m_leds  = bus.leds_on;
         end
         if (ndl != m_dl) hl.delete();
         if (ndr != m_dr) hr.delete();
         m_dlq = m_dl;
         m_drq = m_dr;
         m_dl  = ndl;
         m_dr  = ndr;
         m_sl  = m_s1l;
         m_sr  = m_s1r;
         m_s1l = bus.pbl;
         m_s1r = bus.pbr;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // advance n cycles; every cycle compare all outputs against the model
   task automatic tick(input int n);
      logic [4:0] act, exp;
      repeat (n) begin
         @(negedge clk);
         if (live) begin
            act = {bus.winrnd, bus.right, bus.tie, bus.leds_lat, bus.busy};
            exp = {m_win, m_right, m_tie, m_leds, m_lock};
            n_tests++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL model {win,right,tie,leds,busy}: got %b, expected %b at %0t",
                        act, exp, $time);
            end
            if (bus.winrnd === 1'b1) pulses++;
         end
      end
   endtask

   task automatic wait_arm();
      int k = 0;
      while (bus.busy !== 1'b0 && k < 100) begin
         tick(1);
         k++;
      end
      chk("rearm", int'(bus.busy), 0);
   endtask

   int p0;

   initial begin
      rst = 1'b1;
      bus.pbl = 1'b0;
      bus.pbr = 1'b1;
      bus.leds_on = 1'b0;
      @(negedge clk);
      live = 1'b1;

      // reset hold with pbr pressed
      tick(2);
      chk("reset busy", int'(bus.busy), 1);
      chk("reset winrnd", int'(bus.winrnd), 0);
      chk("reset right", int'(bus.right), 0);
      rst = 1'b0;
      tick(100);
      chk("held pulses", pulses, 0);
      chk("held busy", int'(bus.busy), 1);
      bus.pbr = 1'b0;
      tick(9);
      chk("arm edge-1 busy", int'(bus.busy), 1);
      tick(1);
      chk("arm busy", int'(bus.busy), 0);

      // clean right press
      bus.leds_on = 1'b1;
      bus.pbr = 1'b1;
      tick(6);
      chk("right early win", int'(bus.winrnd), 0);
      tick(1);
      chk("right win", int'(bus.winrnd), 1);
      chk("right right", int'(bus.right), 1);
      chk("right tie", int'(bus.tie), 0);
      chk("right leds", int'(bus.leds_lat), 1);
      chk("right busy", int'(bus.busy), 1);
      tick(1);
      chk("right win off", int'(bus.winrnd), 0);
      chk("right held", int'(bus.right), 1);
      bus.pbr = 1'b0;
      wait_arm();

      // tie
      bus.leds_on = 1'b0;
      bus.pbl = 1'b1;
      bus.pbr = 1'b1;
      tick(7);
      chk("tie win", int'(bus.winrnd), 1);
      chk("tie tie", int'(bus.tie), 1);
      chk("tie right", int'(bus.right), 0);
      chk("tie leds", int'(bus.leds_lat), 0);
      bus.pbl = 1'b0;
      bus.pbr = 1'b0;
      wait_arm();

      // left leads by one cycle
      p0 = pulses;
      bus.pbl = 1'b1;
      tick(1);
      bus.pbr = 1'b1;
      tick(40);
      chk("lead pulses", pulses, p0 + 1);
      chk("lead right", int'(bus.right), 0);
      chk("lead tie", int'(bus.tie), 0);
      bus.pbl = 1'b0;
      bus.pbr = 1'b0;
      wait_arm();

      // glitch of D-1 cycles, then a D-cycle press
      p0 = pulses;
      bus.pbl = 1'b1;
      tick(D - 1);
      bus.pbl = 1'b0;
      tick(20);
      chk("glitch pulses", pulses, p0);
      chk("glitch busy", int'(bus.busy), 0);
      bus.pbl = 1'b1;
      tick(D);
      bus.pbl = 1'b0;
      tick(20);
      chk("short press pulses", pulses, p0 + 1);
      chk("short press right", int'(bus.right), 0);
      wait_arm();

      // lockout: re-press leaving only D-1 quiet edges
      p0 = pulses;
      bus.pbr = 1'b1;
      tick(10);
      chk("lock first", pulses, p0 + 1);
      bus.pbr = 1'b0;
      tick(2 * D - 1);
      bus.pbr = 1'b1;
      tick(10);
      bus.pbr = 1'b0;
      tick(30);
      chk("lock gap D-1", pulses, p0 + 1);

      // lockout: re-press after exactly D quiet edges
      p0 = pulses;
      bus.pbr = 1'b1;
      tick(10);
      bus.pbr = 1'b0;
      tick(2 * D);
      bus.pbr = 1'b1;
      tick(20);
      chk("lock gap D", pulses, p0 + 2);
      bus.pbr = 1'b0;
      wait_arm();

      // randomized traffic with occasional mid-round resets
      for (int seg = 0; seg < 400; seg++) begin
         int len;
         len = $urandom_range(1, 12);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            tick($urandom_range(1, 2));
            rst = 1'b0;
         end
         bus.pbl = ($urandom_range(0, 2) == 0);
         bus.pbr = ($urandom_range(0, 2) == 0);
         for (int c = 0; c < len; c++) begin
            bus.leds_on = $urandom_range(0, 1) == 1;
            tick(1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
